timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 111 +++++++++++
 tb/tb_timer_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Shared countdown timer with round-robin ownership among four requesters.
// The owner loads its value, counts down while enabled, and gets a one-cycle done pulse.
module timer_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    input  logic                  enable,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int IDXW = $clog2(NREQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDXW-1:0]  LAST_INIT = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] last_owner;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand;
    logic [WIDTH-1:0] win_load;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_owner;
        cand      = last_owner;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_owner + IDXW'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_load = load_val[win_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_INIT;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            count      <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= RUN;
                        owner <= win_idx;
                        grant <= ONE_HOT0 << win_idx;
                        count <= win_load;
                        busy  <= 1'b1;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Owner withdrawing wins over a same-edge expiry.
                    if (!req[owner]) begin
                        state      <= IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        count      <= '1;
                        last_owner <= owner;
                    end else if (enable) begin
                        if (count == '0) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= '0;
                    grant      <= '0;
                    busy       <= 1'b0;
                    last_owner <= owner;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    count <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: a transaction-level ownership model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_timer_arbiter;

    localparam int WIDTH = 4;
    localparam int MAXC  = (1 << WIDTH) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [15:0] load_val = 16'b0;
    logic        enable = 1'b0;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  count;
    logic [3:0]  done;

    int checks = 0;
    int failures = 0;

    timer_arbiter #(.WIDTH(WIDTH), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req), .load_val(load_val), .enable(enable),
        .grant(grant), .busy(busy), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_load(input int i, input logic [3:0] v);
        load_val[i*4 +: 4] = v;
    endtask

    // Model: who owns the timer, how much is left, and whether this is the expiry cycle.
    typedef struct {
        int owner;
        int cnt;
        int last;
        bit pulse;
    } mst_t;

    localparam mst_t RST = '{owner: -1, cnt: MAXC, last: 3, pulse: 1'b0};

    function automatic mst_t step(input mst_t s, input logic [3:0] r,
                                  input logic [15:0] lv, input logic en);
        mst_t n = s;
        if (s.pulse) begin
            n.pulse = 1'b0;
            n.last  = s.owner;
            n.owner = -1;
        end else if (s.owner >= 0) begin
            if (!r[s.owner]) begin
                n.last  = s.owner;
                n.owner = -1;
                n.cnt   = MAXC;
            end else if (en) begin
                if (s.cnt == 0) n.pulse = 1'b1;
                else            n.cnt   = s.cnt - 1;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (s.last + k) % 4;
                if (n.owner < 0 && r[c]) begin
                    n.owner = c;
                    n.cnt   = int'(lv[c*4 +: 4]);
                end
            end
        end
        return n;
    endfunction

    mst_t m = RST;

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= RST;
        else        m <= step(m, req, load_val, enable);
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        eg = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_done",  32'(done),  m.pulse ? 32'(eg) : 32'd0);
        chk("model_busy",  32'(busy),  32'(m.owner >= 0));
        chk("model_count", 32'(count), 32'(m.cnt));
    end

    initial begin
        #1 reset = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_count", 32'(count), 32'hF);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Round robin, all loads zero, starting at requester 0 after reset.
        req = 4'b1111;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            @(negedge clk);
            chk("rr_done", 32'(done), 32'(4'b0001 << (i % 4)));
            @(negedge clk);
            chk("rr_idle", 32'(grant), 32'd0);
        end
        req = 4'b0000;

        // Single request, load 3; a later load_val change must not matter.
        set_load(0, 4'd3);
        req = 4'b0001;
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_c3", 32'(count), 32'd3);
        set_load(0, 4'd9);
        @(negedge clk); chk("single_c2", 32'(count), 32'd2);
        @(negedge clk); chk("single_c1", 32'(count), 32'd1);
        @(negedge clk); chk("single_c0", 32'(count), 32'd0);
        chk("single_nodone", 32'(done), 32'd0);
        @(negedge clk); chk("single_done", 32'(done), 32'h1);
        @(negedge clk);
        chk("single_end_grant", 32'(grant), 32'd0);
        chk("single_end_busy", 32'(busy), 32'd0);
        req = 4'b0000;

        // Enable gating, owner 1 with requester 0 also asking (ignored while owned).
        set_load(1, 4'd2);
        set_load(0, 4'd7);
        req = 4'b0011;
        @(negedge clk);
        chk("gate_grant", 32'(grant), 32'h2);
        chk("gate_c0", 32'(count), 32'd2);
        begin
            logic [4:0] en_seq;
            int exp_c[5];
            en_seq = 5'b11001;
            exp_c = '{1, 1, 1, 0, 0};
            for (int i = 0; i < 5; i++) begin
                enable = en_seq[i];
                @(negedge clk);
                chk("gate_count", 32'(count), 32'(exp_c[i]));
                chk("gate_grant_hold", 32'(grant), 32'h2);
            end
        end
        chk("gate_done", 32'(done), 32'h2);
        @(negedge clk);
        chk("gate_end", 32'(grant), 32'd0);
        req = 4'b0000;
        enable = 1'b1;

        // Reset in the middle of a countdown.
        set_load(2, 4'd4);
        req = 4'b0100;
        @(negedge clk);
        chk("rrun_grant", 32'(grant), 32'h4);
        @(negedge clk);
        @(negedge clk);
        chk("rrun_c2", 32'(count), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("rrun_grant0", 32'(grant), 32'd0);
        chk("rrun_done0", 32'(done), 32'd0);
        chk("rrun_busy0", 32'(busy), 32'd0);
        chk("rrun_countF", 32'(count), 32'hF);
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1001;
        set_load(0, 4'd6);
        @(negedge clk);
        chk("rrun_first", 32'(grant), 32'h1);
        chk("rrun_count", 32'(count), 32'd6);
        req = 4'b0000;
        @(negedge clk);
        chk("drop_count", 32'(count), 32'hF);

        // Abort at count 5; requester 3 takes over after one idle cycle.
        set_load(2, 4'd9);
        set_load(3, 4'd0);
        req = 4'b0100;
        @(negedge clk);
        chk("abort_grant", 32'(grant), 32'h4);
        repeat (4) @(negedge clk);
        chk("abort_c5", 32'(count), 32'd5);
        req = 4'b1000;
        @(negedge clk);
        chk("abort_grant0", 32'(grant), 32'd0);
        chk("abort_countF", 32'(count), 32'hF);
        chk("abort_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_next", 32'(grant), 32'h8);
        chk("abort_next_c", 32'(count), 32'd0);

        // Expiry and abort on the same edge: abort wins.
        req = 4'b0000;
        @(negedge clk);
        chk("both_grant", 32'(grant), 32'd0);
        chk("both_done", 32'(done), 32'd0);
        chk("both_count", 32'(count), 32'hF);
        @(negedge clk);
        chk("both_done_late", 32'(done), 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
